// File: rtl/nnarm_mem_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: state encoding and
// default bus widths.
package nnarm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2,
        IF_DROP = 2'd3
    } arb_state_e;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory bus. MEM has
// priority, bounded by a run counter so IF cannot starve.
module mem_port_arbiter
    import nnarm_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_MEM_RUN = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_IFRequest,
    input  logic [ADDR_WIDTH-1:0]   in_IFAddress,
    input  logic                    in_IFFlush,
    input  logic                    in_MEMRequest,
    input  logic                    in_MEMWrite,
    input  logic [ADDR_WIDTH-1:0]   in_MEMAddress,
    input  logic [DATA_WIDTH-1:0]   in_MEMWriteData,
    input  logic [DATA_WIDTH/8-1:0] in_MEMByteEnable,
    output logic                    out_IFOwnCanGo,
    output logic                    out_MEMOwnCanGo,
    output logic [DATA_WIDTH-1:0]   out_IFReadData,
    output logic [DATA_WIDTH-1:0]   out_MEMReadData,
    output logic                    out_BusRequest,
    output logic                    out_BusWrite,
    output logic [ADDR_WIDTH-1:0]   out_BusAddress,
    output logic [DATA_WIDTH-1:0]   out_BusWriteData,
    output logic [DATA_WIDTH/8-1:0] out_BusByteEnable,
    input  logic                    in_BusReady,
    input  logic [DATA_WIDTH-1:0]   in_BusReadData
);

    localparam int RUN_W = $clog2(MAX_MEM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_MEM_RUN);

    arb_state_e            state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  grant_mem, grant_if;

    always_comb begin
        grant_mem = (state_q == IDLE) && in_MEMRequest
                    && !(in_IFRequest && (run_q == RUN_MAX));
        grant_if  = (state_q == IDLE) && !grant_mem && in_IFRequest && !in_IFFlush;

        state_d = state_q;
        run_d   = run_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d = MEM_ACC;
                    // Count only MEM grants that actually make IF wait.
                    if (!in_IFRequest)
                        run_d = '0;
                    else if (run_q != RUN_MAX)
                        run_d = run_q + RUN_W'(1);
                end else if (grant_if) begin
                    state_d = IF_ACC;
                    run_d   = '0;
                    addr_d  = in_IFAddress;
                end
            end
            IF_ACC: begin
                if (in_BusReady)
                    state_d = IDLE;
                else if (in_IFFlush)
                    state_d = IF_DROP;
            end
            MEM_ACC, IF_DROP: begin
                if (in_BusReady)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            addr_q  <= addr_d;
        end
    end

    // Bus control is decoded from registered state only; the IF address comes
    // from the latch so a flushed fetch keeps its original address while draining.
    always_comb begin
        out_BusRequest    = (state_q != IDLE);
        out_BusWrite      = 1'b0;
        out_BusAddress    = '0;
        out_BusWriteData  = '0;
        out_BusByteEnable = '0;
        case (state_q)
            MEM_ACC: begin
                out_BusWrite      = in_MEMWrite;
                out_BusAddress    = in_MEMAddress;
                out_BusWriteData  = in_MEMWriteData;
                out_BusByteEnable = in_MEMByteEnable;
            end
            IF_ACC, IF_DROP: begin
                out_BusAddress    = addr_q;
                out_BusByteEnable = '1;
            end
            default: ;
        endcase
    end

    assign out_IFOwnCanGo  = !reset && (!in_IFRequest
                             || ((state_q == IF_ACC) && in_BusReady));
    assign out_MEMOwnCanGo = !reset && (!in_MEMRequest
                             || ((state_q == MEM_ACC) && in_BusReady));

    assign out_IFReadData  = in_BusReadData;
    assign out_MEMReadData = in_BusReadData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the memory-port arbiter: pass-through, single fetch,
// priority, flush drain, starvation guard and reset mid-access.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_IFRequest;
    logic [31:0] in_IFAddress;
    logic        in_IFFlush;
    logic        in_MEMRequest;
    logic        in_MEMWrite;
    logic [31:0] in_MEMAddress;
    logic [31:0] in_MEMWriteData;
    logic [3:0]  in_MEMByteEnable;
    logic        out_IFOwnCanGo;
    logic        out_MEMOwnCanGo;
    logic [31:0] out_IFReadData;
    logic [31:0] out_MEMReadData;
    logic        out_BusRequest;
    logic        out_BusWrite;
    logic [31:0] out_BusAddress;
    logic [31:0] out_BusWriteData;
    logic [3:0]  out_BusByteEnable;
    logic        in_BusReady;
    logic [31:0] in_BusReadData;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_MEM_RUN(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_IFRequest(in_IFRequest),
        .in_IFAddress(in_IFAddress),
        .in_IFFlush(in_IFFlush),
        .in_MEMRequest(in_MEMRequest),
        .in_MEMWrite(in_MEMWrite),
        .in_MEMAddress(in_MEMAddress),
        .in_MEMWriteData(in_MEMWriteData),
        .in_MEMByteEnable(in_MEMByteEnable),
        .out_IFOwnCanGo(out_IFOwnCanGo),
        .out_MEMOwnCanGo(out_MEMOwnCanGo),
        .out_IFReadData(out_IFReadData),
        .out_MEMReadData(out_MEMReadData),
        .out_BusRequest(out_BusRequest),
        .out_BusWrite(out_BusWrite),
        .out_BusAddress(out_BusAddress),
        .out_BusWriteData(out_BusWriteData),
        .out_BusByteEnable(out_BusByteEnable),
        .in_BusReady(in_BusReady),
        .in_BusReadData(in_BusReadData)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serves every bus access with zero wait states and records the owner of
    // each grant (M = MEM address 0x2000, I = anything else).
    task automatic collect(input int n, input bit finish_last, output string s);
        string c;
        s = "";
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            in_BusReady = 1'b0;
            #1;
            if (out_BusRequest) begin
                c = (out_BusAddress == 32'h2000) ? "M" : "I";
                s = {s, c};
                if (s.len() == n && !finish_last) break;
                in_BusReady = 1'b1;
                if (s.len() == n) begin
                    tick();
                    in_BusReady = 1'b0;
                    break;
                end
            end
        end
    endtask

    initial begin
        string got;
        string exp_a;
        string exp_b;

        reset            = 1'b1;
        in_IFRequest     = 1'b0;
        in_IFAddress     = 32'h0;
        in_IFFlush       = 1'b0;
        in_MEMRequest    = 1'b0;
        in_MEMWrite      = 1'b0;
        in_MEMAddress    = 32'h0;
        in_MEMWriteData  = 32'h0;
        in_MEMByteEnable = 4'h0;
        in_BusReady      = 1'b0;
        in_BusReadData   = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_busreq", 32'(out_BusRequest), 32'd0);
        check("rst_if_cango", 32'(out_IFOwnCanGo), 32'd0);
        check("rst_mem_cango", 32'(out_MEMOwnCanGo), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_if_cango", 32'(out_IFOwnCanGo), 32'd1);
        check("idle_mem_cango", 32'(out_MEMOwnCanGo), 32'd1);
        tick();
        check("idle_busreq", 32'(out_BusRequest), 32'd0);

        // Single fetch
        in_IFRequest = 1'b1;
        in_IFAddress = 32'h100;
        #1;
        check("sf_grant_busreq", 32'(out_BusRequest), 32'd0);
        check("sf_grant_cango", 32'(out_IFOwnCanGo), 32'd0);
        tick();
        in_BusReady    = 1'b1;
        in_BusReadData = 32'hE3A00001;
        #1;
        check("sf_busreq", 32'(out_BusRequest), 32'd1);
        check("sf_addr", out_BusAddress, 32'h100);
        check("sf_write", 32'(out_BusWrite), 32'd0);
        check("sf_be", 32'(out_BusByteEnable), 32'hF);
        check("sf_cango", 32'(out_IFOwnCanGo), 32'd1);
        check("sf_rdata", out_IFReadData, 32'hE3A00001);
        tick();
        in_BusReady  = 1'b0;
        in_IFRequest = 1'b0;
        #1;
        check("sf_busreq_after", 32'(out_BusRequest), 32'd0);

        // Simultaneous requests: MEM store first, then IF
        in_IFRequest     = 1'b1;
        in_MEMRequest    = 1'b1;
        in_MEMWrite      = 1'b1;
        in_MEMAddress    = 32'h2000;
        in_MEMWriteData  = 32'hDEADBEEF;
        in_MEMByteEnable = 4'hF;
        #1;
        check("sim_idle_busreq", 32'(out_BusRequest), 32'd0);
        check("sim_idle_ifcango", 32'(out_IFOwnCanGo), 32'd0);
        check("sim_idle_memcango", 32'(out_MEMOwnCanGo), 32'd0);
        tick();
        check("sim_m_busreq", 32'(out_BusRequest), 32'd1);
        check("sim_m_write", 32'(out_BusWrite), 32'd1);
        check("sim_m_addr", out_BusAddress, 32'h2000);
        check("sim_m_wdata", out_BusWriteData, 32'hDEADBEEF);
        check("sim_m_be", 32'(out_BusByteEnable), 32'hF);
        check("sim_m_wait_memcango", 32'(out_MEMOwnCanGo), 32'd0);
        tick();
        in_BusReady = 1'b1;
        #1;
        check("sim_m_rdy_memcango", 32'(out_MEMOwnCanGo), 32'd1);
        check("sim_m_rdy_ifcango", 32'(out_IFOwnCanGo), 32'd0);
        tick();
        in_BusReady   = 1'b0;
        in_MEMRequest = 1'b0;
        in_MEMWrite   = 1'b0;
        #1;
        check("sim_gap_busreq", 32'(out_BusRequest), 32'd0);
        check("sim_gap_ifcango", 32'(out_IFOwnCanGo), 32'd0);
        tick();
        in_BusReady    = 1'b1;
        in_BusReadData = 32'h12345678;
        #1;
        check("sim_i_addr", out_BusAddress, 32'h100);
        check("sim_i_write", 32'(out_BusWrite), 32'd0);
        check("sim_i_cango", 32'(out_IFOwnCanGo), 32'd1);
        check("sim_i_rdata", out_IFReadData, 32'h12345678);
        tick();
        in_BusReady = 1'b0;

        // Flush in IDLE blocks the IF grant
        in_IFAddress = 32'h300;
        in_IFFlush   = 1'b1;
        tick();
        in_IFFlush = 1'b0;
        #1;
        check("flidle_busreq", 32'(out_BusRequest), 32'd0);

        // Flush drain with three wait cycles
        tick();
        in_IFFlush   = 1'b1;
        in_IFAddress = 32'h400;
        #1;
        check("drain_acc_busreq", 32'(out_BusRequest), 32'd1);
        check("drain_acc_addr", out_BusAddress, 32'h300);
        tick();
        in_IFFlush = 1'b0;
        #1;
        check("drain_w2_busreq", 32'(out_BusRequest), 32'd1);
        check("drain_w2_addr", out_BusAddress, 32'h300);
        tick();
        check("drain_w3_addr", out_BusAddress, 32'h300);
        tick();
        in_BusReady = 1'b1;
        #1;
        check("drain_rdy_addr", out_BusAddress, 32'h300);
        check("drain_rdy_cango", 32'(out_IFOwnCanGo), 32'd0);
        tick();
        in_BusReady = 1'b0;
        #1;
        check("drain_idle_busreq", 32'(out_BusRequest), 32'd0);
        tick();
        in_BusReady = 1'b1;
        #1;
        check("refetch_addr", out_BusAddress, 32'h400);
        check("refetch_cango", 32'(out_IFOwnCanGo), 32'd1);
        tick();
        in_BusReady = 1'b0;

        // Flush together with ready completes normally
        tick();
        in_IFFlush  = 1'b1;
        in_BusReady = 1'b1;
        #1;
        check("flrdy_cango", 32'(out_IFOwnCanGo), 32'd1);
        tick();
        in_IFFlush   = 1'b0;
        in_BusReady  = 1'b0;
        in_IFRequest = 1'b0;
        #1;
        check("flrdy_busreq", 32'(out_BusRequest), 32'd0);

        // Starvation guard: both request continuously
        in_IFAddress  = 32'h100;
        in_IFRequest  = 1'b1;
        in_MEMRequest = 1'b1;
        in_MEMWrite   = 1'b0;
        in_MEMAddress = 32'h2000;
        exp_a = "MMMMIMMM";
        collect(8, 1'b0, got);
        check("starve_len", 32'(got.len()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("starve_order[%0d]", i), 32'(got[i]), 32'(exp_a[i]));

        // Reset while the 8th grant (MEM, run count 3) is in progress
        reset       = 1'b1;
        in_BusReady = 1'b1;
        #1;
        check("rstacc_memcango", 32'(out_MEMOwnCanGo), 32'd0);
        tick();
        in_BusReady  = 1'b0;
        in_IFRequest = 1'b0;
        #1;
        check("rstacc_busreq", 32'(out_BusRequest), 32'd0);
        check("rstacc_ifcango", 32'(out_IFOwnCanGo), 32'd0);
        check("rstacc_memcango2", 32'(out_MEMOwnCanGo), 32'd0);
        reset        = 1'b0;
        in_IFRequest = 1'b1;
        exp_b = "MMMMI";
        collect(5, 1'b1, got);
        check("rst_run_len", 32'(got.len()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rst_run_order[%0d]", i), 32'(got[i]), 32'(exp_b[i]));

        in_IFRequest  = 1'b0;
        in_MEMRequest = 1'b0;
        tick();
        check("end_busreq", 32'(out_BusRequest), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
